// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one single-port RAM between instruction fetch and data access.
// Holds the whole pipeline in stall until every pending access of the current cycle has completed.
module mem_arbiter #(
    parameter int ADDR_BITS  = 32,
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inst_ren,
    input  logic [ADDR_BITS-1:0] inst_addr,
    output logic [31:0]          inst_data,
    input  logic                 mem_ren,
    input  logic                 mem_wen,
    input  logic [ADDR_BITS-1:0] mem_addr,
    input  logic [31:0]          mem_dout,
    output logic [31:0]          mem_din,
    output logic                 stall,
    output logic                 ram_cs,
    output logic                 ram_we,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [31:0]          ram_wdata,
    input  logic [31:0]          ram_rdata,
    input  logic                 ram_ack,
    output logic [31:0]          stall_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_D,
        BUSY_I
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic                 r_iDone;
    logic                 r_dDone;
    logic                 r_ramCs;
    logic                 r_ramWe;
    logic [ADDR_BITS-1:0] r_ramAddr;
    logic [31:0]          r_ramWdata;
    logic [31:0]          r_instData;
    logic [31:0]          r_memDin;
    logic [31:0]          r_stallCnt;

    logic w_dReq;
    logic w_dPend;
    logic w_iPend;
    logic w_stall;
    logic w_issueD;
    logic w_issueI;
    logic w_doneD;
    logic w_doneI;

    // A port stops stalling once its done flag is set; flags clear on the advance cycle.
    assign w_dReq  = mem_ren | mem_wen;
    assign w_dPend = w_dReq & ~r_dDone;
    assign w_iPend = inst_ren & ~r_iDone;
    assign w_stall = w_iPend | w_dPend;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_issueD    = 1'b0;
        w_issueI    = 1'b0;
        w_doneD     = 1'b0;
        w_doneI     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_dPend && (DATA_FIRST || !w_iPend)) begin
                    w_issueD    = 1'b1;
                    w_nextState = BUSY_D;
                end else if (w_iPend) begin
                    w_issueI    = 1'b1;
                    w_nextState = BUSY_I;
                end
            end
            BUSY_D: begin
                if (ram_ack) begin
                    w_doneD     = 1'b1;
                    w_nextState = IDLE;
                end
            end
            BUSY_I: begin
                if (ram_ack) begin
                    w_doneI     = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // RAM request registers stay frozen from issue until the ack arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ramCs    <= 1'b0;
            r_ramWe    <= 1'b0;
            r_ramAddr  <= '0;
            r_ramWdata <= '0;
            r_instData <= '0;
            r_memDin   <= '0;
        end else begin
            if (w_issueD) begin
                r_ramCs    <= 1'b1;
                r_ramWe    <= mem_wen;
                r_ramAddr  <= mem_addr;
                r_ramWdata <= mem_dout;
            end else if (w_issueI) begin
                r_ramCs   <= 1'b1;
                r_ramWe   <= 1'b0;
                r_ramAddr <= inst_addr;
            end else if (w_doneD || w_doneI) begin
                r_ramCs <= 1'b0;
                r_ramWe <= 1'b0;
            end
            if (w_doneD && !r_ramWe) begin
                r_memDin <= ram_rdata;
            end
            if (w_doneI) begin
                r_instData <= ram_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_iDone    <= 1'b0;
            r_dDone    <= 1'b0;
            r_stallCnt <= '0;
        end else begin
            if (!w_stall) begin
                r_iDone <= 1'b0;
                r_dDone <= 1'b0;
            end else begin
                if (w_doneI) r_iDone <= 1'b1;
                if (w_doneD) r_dDone <= 1'b1;
            end
            if (w_stall && (r_stallCnt != 32'hFFFF_FFFF)) begin
                r_stallCnt <= r_stallCnt + 32'd1;
            end
        end
    end

    assign stall     = w_stall;
    assign ram_cs    = r_ramCs;
    assign ram_we    = r_ramWe;
    assign ram_addr  = r_ramAddr;
    assign ram_wdata = r_ramWdata;
    assign inst_data = r_instData;
    assign mem_din   = r_memDin;
    assign stall_cnt = r_stallCnt;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port memory between the core's instruction-fetch interface (`inst_*`) and its data-memory interface (`mem_*`). Sits between `mips_core` and a unified RAM. Serialises the two requests with a fixed-priority FSM and drives one global `stall` that freezes the whole pipeline until every pending access has completed. The RAM side uses a simple request/ack handshake, so wait-state memories are supported.

## Interface
- `ADDR_BITS`, 32, width of all addresses.
- `DATA_FIRST`, 1: 1 = data port has priority, 0 = instruction port has priority.
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `inst_ren` in 1: fetch request, level, held by the core while `stall`=1.
- `inst_addr` in ADDR_BITS: fetch address.
- `inst_data` out 32: fetched word, registered.
- `mem_ren` in 1: data read request, level.
- `mem_wen` in 1: data write request, level. `mem_ren` and `mem_wen` are never both 1.
- `mem_addr` in ADDR_BITS: data address.
- `mem_dout` in 32: write data from the core.
- `mem_din` out 32: read data to the core, registered.
- `stall` out 1: pipeline freeze, combinational.
- `ram_cs` out 1: RAM access strobe, registered.
- `ram_we` out 1: RAM write, registered.
- `ram_addr` out ADDR_BITS: registered.
- `ram_wdata` out 32: registered.
- `ram_rdata` in 32: RAM read data, valid when `ram_ack`=1.
- `ram_ack` in 1: access complete. May be high in the first cycle `ram_cs` is high.
- `stall_cnt` out 32: saturating count of cycles with `stall`=1.

## Operation
- Terms:
  - `d_req` = `mem_ren` | `mem_wen`.
  - Per-port done flags: `i_done` and `d_done`.
  - `stall` = (`inst_ren` & ~`i_done`) | (`d_req` & ~`d_done`).
- FSM states: IDLE, BUSY_D, BUSY_I.
- IDLE:
  - Pending ports are `d_req` & ~`d_done` and `inst_ren` & ~`i_done`.
  - If any port is pending, choose one per `DATA_FIRST`.
  - Latch address and write data into the `ram_*` registers, set `ram_cs`=1.
  - `ram_we` = `mem_wen` for a data access, 0 for an instruction access.
  - Next state is BUSY_D or BUSY_I.
- BUSY_x:
  - Hold all `ram_*` outputs stable until `ram_ack`.
  - On `ram_ack`:
    - Clear `ram_cs`/`ram_we`.
    - Set the matching done flag.
    - For a read, latch `ram_rdata` into `inst_data` or `mem_din`. A write leaves `mem_din` unchanged.
    - Next state IDLE.
- Advance cycle: any cycle with `stall`=0.
  - At its closing edge, clear both done flags. The core presents new requests in the following cycle.
  - IDLE never issues in an advance cycle, because every active port is already done.
- `ram_ack` in IDLE is ignored.
- Request inputs are sampled only in IDLE. Changes while in BUSY_x are illegal, since the core holds them while stalled.
- `inst_data` and `mem_din` keep their last value until overwritten.
- `stall_cnt` increments on every cycle with `stall`=1 and saturates at 0xFFFFFFFF.

## Timing
- Reset values:
  - state IDLE.
  - `ram_cs`=0, `ram_we`=0.
  - `ram_addr`=0, `ram_wdata`=0.
  - `inst_data`=0, `mem_din`=0.
  - `i_done`=0, `d_done`=0.
  - `stall_cnt`=0.
  - `stall` then follows the request inputs combinationally.
- Single access with the RAM acking k cycles after `ram_cs` rises (k≥0):
  - Request in cycle 0.
  - `ram_cs` high in cycles 1..1+k.
  - Done flag set and `stall`=0 in cycle 2+k.
  - Result register valid in cycle 2+k.
- Both ports requesting at once, zero-wait RAM, `DATA_FIRST`=1:
  - Data issued in cycle 0, `ram_cs` in cycle 1.
  - Instruction issued in cycle 2, `ram_cs` in cycle 3.
  - `stall`=1 in cycles 0–3, advance in cycle 4.
- No requests: `stall`=0, RAM idle.
- `rst` during BUSY_x:
  - Abort the access, `ram_cs`=0 at the next edge.
  - A late `ram_ack` after reset is ignored.
- At most one RAM access outstanding at any time. `ram_cs` never rises in the cycle right after an ack.

## Test plan
- **Reset:** assert `rst` 2 cycles while `inst_ren`=1 and RAM acking. Expect `ram_cs`=0, `inst_data`=0, `stall_cnt`=0, and `stall`=1 in the first cycle after reset.
- **Lone fetch:** `inst_ren`=1, `inst_addr`=0x40, RAM returns 0x2408000A with zero wait. Expect `ram_cs` in cycle 1 with addr 0x40 and `ram_we`=0, `stall`=0 and `inst_data`=0x2408000A in cycle 2, done flag cleared after cycle 2.
- **Fetch plus write:** `inst_ren` with addr 0x44, `mem_wen` with addr 0x100 and data 0xDEADBEEF, zero wait, `DATA_FIRST`=1. Expect the write first (`ram_we`=1, addr 0x100) in cycle 1, then the fetch in cycle 3, advance in cycle 4, `stall_cnt`=4, `mem_din` unchanged.
- **Priority swap:** same stimulus with `DATA_FIRST`=0. Expect the fetch in cycle 1 and the write in cycle 3.
- **Wait states:** `mem_ren` addr 0x200, RAM acks after 3 cycles with 0x12345678. Expect `ram_cs` high in cycles 1–4 with stable addr, `mem_din`=0x12345678 and `stall`=0 in cycle 5.
- **Reset mid-access:** `rst` in cycle 2 of a 5-wait read, with `ram_ack` pulsed 2 cycles later. Expect the FSM to stay IDLE, no done flag set, `mem_din` unchanged at 0.
